// File: rtl/ex_stage_md.sv
// Execute stage: forwarding ALU, branch/jump resolution and an iterative
// MUL/MULHU/DIVU/REMU unit, all feeding the EX/MEM output register.
module ex_stage_md #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int MD_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [3:0]      in_op,
    input  logic            in_src_b_imm,
    input  logic            in_branch,
    input  logic            in_jump,
    input  logic            in_jalr,
    input  logic [2:0]      in_funct3,
    input  logic            in_reg_write,
    input  logic            in_mem_read,
    input  logic            in_mem_write,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rdata1,
    input  logic [XLEN-1:0] in_rdata2,
    input  logic [XLEN-1:0] in_imm,
    input  logic [RA_W-1:0] in_rs1,
    input  logic [RA_W-1:0] in_rs2,
    input  logic [RA_W-1:0] in_rd,
    input  logic [XLEN-1:0] exm_result,
    input  logic [RA_W-1:0] exm_rd,
    input  logic            exm_reg_write,
    input  logic [XLEN-1:0] wb_data,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_reg_write,
    input  logic            mem_stall,
    input  logic            flush,
    output logic            ex_busy,
    output logic            out_valid,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_store_data,
    output logic [RA_W-1:0] out_rd,
    output logic            out_redirect,
    output logic [XLEN-1:0] out_redirect_target,
    output logic [1:0]      dbg_state
);
    localparam int SH_W = $clog2(XLEN);
    localparam logic [SH_W-1:0] CNT_LAST = SH_W'(XLEN - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_e;

    state_e            state_q, state_d;
    logic [SH_W-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, m_q, m_d;
    logic [3:0]        md_op_q, md_op_d;
    logic              valid_q, valid_d, rw_q, rw_d, mr_q, mr_d, mw_q, mw_d, redir_q, redir_d;
    logic [XLEN-1:0]   result_q, result_d, store_q, store_d, target_q, target_d;
    logic [RA_W-1:0]   rd_q, rd_d;

    logic [XLEN-1:0]   fwd_a, fwd_b, op_b, alu_res, sc_result, jalr_sum, target, md_result;
    logic [XLEN-1:0]   div_diff;
    logic [XLEN:0]     mul_sum, div_r;
    logic [SH_W-1:0]   shamt;
    logic              br_taken, is_jump, redirect, is_mop, is_mul, div_ge;
    logic              busy, load_sc, load_md;

    // EX/MEM result takes priority over MEM/WB; x0 is never forwarded.
    always_comb begin
        if (exm_reg_write && in_rs1 != '0 && exm_rd == in_rs1)     fwd_a = exm_result;
        else if (wb_reg_write && in_rs1 != '0 && wb_rd == in_rs1)  fwd_a = wb_data;
        else                                                       fwd_a = in_rdata1;
        if (exm_reg_write && in_rs2 != '0 && exm_rd == in_rs2)     fwd_b = exm_result;
        else if (wb_reg_write && in_rs2 != '0 && wb_rd == in_rs2)  fwd_b = wb_data;
        else                                                       fwd_b = in_rdata2;
    end

    assign op_b  = in_src_b_imm ? in_imm : fwd_b;
    assign shamt = op_b[SH_W-1:0];

    always_comb begin
        alu_res = fwd_a + op_b;
        case (in_op)
            4'd1:    alu_res = fwd_a - op_b;
            4'd2:    alu_res = fwd_a & op_b;
            4'd3:    alu_res = fwd_a | op_b;
            4'd4:    alu_res = fwd_a ^ op_b;
            4'd5:    alu_res = fwd_a << shamt;
            4'd6:    alu_res = fwd_a >> shamt;
            4'd7:    alu_res = $unsigned($signed(fwd_a) >>> shamt);
            4'd8:    alu_res = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(op_b)};
            4'd9:    alu_res = {{(XLEN-1){1'b0}}, fwd_a < op_b};
            4'd10:   alu_res = op_b;
            default: ;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (in_funct3)
            3'b000:  br_taken = (fwd_a == fwd_b);
            3'b001:  br_taken = (fwd_a != fwd_b);
            3'b100:  br_taken = ($signed(fwd_a) < $signed(fwd_b));
            3'b101:  br_taken = ($signed(fwd_a) >= $signed(fwd_b));
            3'b110:  br_taken = (fwd_a < fwd_b);
            3'b111:  br_taken = (fwd_a >= fwd_b);
            default: br_taken = 1'b0;
        endcase
    end

    assign is_jump   = in_jump | in_jalr;
    assign jalr_sum  = fwd_a + in_imm;
    assign target    = in_jalr ? (jalr_sum & ~XLEN'(1)) : (in_pc + in_imm);
    assign sc_result = is_jump ? (in_pc + XLEN'(4)) : alu_res;
    assign redirect  = in_valid & (is_jump | (in_branch & br_taken));

    assign is_mop = (MD_EN != 0) && (in_op >= 4'd11) && (in_op <= 4'd14);
    assign is_mul = (in_op == 4'd11) || (in_op == 4'd12);

    // {hi,lo} is the shifting product for MUL/MULHU, {remainder,quotient} for DIVU/REMU.
    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    assign div_r    = {hi_q, lo_q[XLEN-1]};
    assign div_ge   = (div_r >= {1'b0, m_q});
    assign div_diff = div_r[XLEN-1:0] - m_q;

    always_comb begin
        case (md_op_q)
            4'd11:   md_result = lo_q;
            4'd13:   md_result = lo_q;
            default: md_result = hi_q;
        endcase
    end

    // ex_busy high: upstream holds every in_* stable; out_valid qualifies the EX/MEM register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        m_d     = m_q;
        md_op_d = md_op_q;
        busy    = 1'b0;
        load_sc = 1'b0;
        load_md = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid && is_mop && !flush) begin
                    busy    = 1'b1;
                    state_d = S_RUN;
                    cnt_d   = '0;
                    hi_d    = '0;
                    lo_d    = is_mul ? op_b : fwd_a;
                    m_d     = is_mul ? fwd_a : op_b;
                    md_op_d = in_op;
                end else begin
                    load_sc = 1'b1;
                end
            end
            S_RUN: begin
                busy  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (md_op_q == 4'd11 || md_op_q == 4'd12) begin
                    hi_d = mul_sum[XLEN:1];
                    lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                end else begin
                    hi_d = div_ge ? div_diff : div_r[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], div_ge};
                end
                if (cnt_q == CNT_LAST) state_d = S_DONE;
            end
            S_DONE: begin
                busy = mem_stall;
                if (!mem_stall) begin
                    load_md = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    always_comb begin
        valid_d  = valid_q;
        rw_d     = rw_q;
        mr_d     = mr_q;
        mw_d     = mw_q;
        redir_d  = redir_q;
        result_d = result_q;
        store_d  = store_q;
        rd_d     = rd_q;
        target_d = target_q;
        if (!mem_stall) begin
            valid_d  = 1'b0;
            rw_d     = 1'b0;
            mr_d     = 1'b0;
            mw_d     = 1'b0;
            redir_d  = 1'b0;
            result_d = sc_result;
            store_d  = fwd_b;
            rd_d     = in_rd;
            target_d = target;
            if (!flush && ((load_sc && in_valid) || load_md)) begin
                valid_d = 1'b1;
                rw_d    = in_reg_write;
                mr_d    = in_mem_read;
                mw_d    = in_mem_write;
                redir_d = load_sc & redirect;
                if (load_md) result_d = md_result;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            m_q      <= '0;
            md_op_q  <= '0;
            valid_q  <= 1'b0;
            rw_q     <= 1'b0;
            mr_q     <= 1'b0;
            mw_q     <= 1'b0;
            redir_q  <= 1'b0;
            result_q <= '0;
            store_q  <= '0;
            rd_q     <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            m_q      <= m_d;
            md_op_q  <= md_op_d;
            valid_q  <= valid_d;
            rw_q     <= rw_d;
            mr_q     <= mr_d;
            mw_q     <= mw_d;
            redir_q  <= redir_d;
            result_q <= result_d;
            store_q  <= store_d;
            rd_q     <= rd_d;
            target_q <= target_d;
        end
    end

    assign ex_busy             = rst & busy;
    assign out_valid           = valid_q;
    assign out_reg_write       = rw_q;
    assign out_mem_read        = mr_q;
    assign out_mem_write       = mw_q;
    assign out_redirect        = redir_q;
    assign out_result          = result_q;
    assign out_store_data      = store_q;
    assign out_rd              = rd_q;
    assign out_redirect_target = target_q;
    assign dbg_state           = state_q;
endmodule
